// File: rtl/bsg_arb_rr_lock.sv
// Round-robin arbiter with a registered last-grant pointer and combinational grant path.
// Define BSG_ARB_RR_LOCK_EN to add lock_i and hold an accepted grant across multi-beat transfers.
module bsg_arb_rr_lock #(
  parameter  int inputs_p     = 16,
  localparam int tag_width_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    ready_i,
  input  logic [inputs_p-1:0]     reqs_i,
`ifdef BSG_ARB_RR_LOCK_EN
  input  logic                    lock_i,
`endif
  input  logic                    yumi_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o
);

  logic [tag_width_lp-1:0] last_q, last_d;
  logic [inputs_p-1:0]     hi_mask;
  logic [inputs_p-1:0]     hi_reqs;
  logic [inputs_p-1:0]     pick_vec;
  logic [inputs_p-1:0]     rr_onehot;
  logic [inputs_p-1:0]     cand_onehot;
  logic [inputs_p-1:0]     bit_sel [tag_width_lp];

  // Requesters above last_q outrank those at or below it, giving modulo-N rotation.
  for (genvar gi = 0; gi < inputs_p; gi++) begin : g_mask
    assign hi_mask[gi] = (tag_width_lp'(gi) > last_q);
  end

  assign hi_reqs   = reqs_i & hi_mask;
  assign pick_vec  = (|hi_reqs) ? hi_reqs : reqs_i;
  assign rr_onehot = pick_vec & (~pick_vec + inputs_p'(1));

`ifdef BSG_ARB_RR_LOCK_EN
  logic                    lock_q, lock_d;
  logic [tag_width_lp-1:0] lock_idx_q, lock_idx_d;
  logic [inputs_p-1:0]     lock_onehot;

  for (genvar gi = 0; gi < inputs_p; gi++) begin : g_lock
    assign lock_onehot[gi] = (lock_idx_q == tag_width_lp'(gi));
  end

  assign cand_onehot = lock_q ? (lock_onehot & reqs_i) : rr_onehot;
`else
  assign cand_onehot = rr_onehot;
`endif

  assign grants_o = (reset_i || !ready_i) ? '0 : cand_onehot;
  assign v_o      = |grants_o;

  // Binary encode: tag bit b is the OR of grants whose index has bit b set.
  for (genvar gb = 0; gb < tag_width_lp; gb++) begin : g_enc_bit
    for (genvar gi = 0; gi < inputs_p; gi++) begin : g_enc_idx
      if (((gi >> gb) & 1) == 1) begin : g_on
        assign bit_sel[gb][gi] = grants_o[gi];
      end else begin : g_off
        assign bit_sel[gb][gi] = 1'b0;
      end
    end
    assign tag_o[gb] = |bit_sel[gb];
  end

  always_comb begin
    last_d = last_q;
`ifdef BSG_ARB_RR_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    if (yumi_i && v_o) begin
      // While locked tag_o equals lock_idx_q, so release resumes rotation after it.
      last_d = tag_o;
`ifdef BSG_ARB_RR_LOCK_EN
      lock_d = lock_i;
      if (lock_i) lock_idx_d = tag_o;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= tag_width_lp'(inputs_p - 1);
`ifdef BSG_ARB_RR_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      last_q <= last_d;
`ifdef BSG_ARB_RR_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
`endif

endmodule
